// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP ALU issue stage: opcodes, the canonical quiet NaN and the FSM state set.
package fp_alu_pkg;

  localparam logic [2:0]  OP_FADD  = 3'd0;
  localparam logic [2:0]  OP_FSUB  = 3'd1;
  localparam logic [2:0]  OP_FMULT = 3'd2;
  localparam logic [2:0]  OP_FABS  = 3'd3;
  localparam logic [2:0]  OP_FSLT  = 3'd4;
  localparam logic [2:0]  OP_FSIN  = 3'd5;

  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SIN_START,
    ST_SIN_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/fp_alu_issue_if.sv
// Request/response handshake bundle between the issue stage (slave) and its client (master).
interface fp_alu_issue_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_res;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_res, resp_tag, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_res, resp_tag, resp_err
  );
endinterface

// File: rtl/fp_alu_issue_stats.sv
// Saturating activity counters for the issue stage (built only with FP_ALU_ISSUE_STATS_EN).
module fp_alu_issue_stats (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_resp_hs,
  input  logic        i_sin_wait,
  input  logic        i_timeout,
  output logic [31:0] o_ops,
  output logic [31:0] o_sin_cycles,
  output logic [15:0] o_timeouts
);
  logic [31:0] r_ops;
  logic [31:0] r_sin_cycles;
  logic [15:0] r_timeouts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ops        <= '0;
      r_sin_cycles <= '0;
      r_timeouts   <= '0;
    end else begin
      if (i_resp_hs && !(&r_ops))         r_ops        <= r_ops + 32'd1;
      if (i_sin_wait && !(&r_sin_cycles)) r_sin_cycles <= r_sin_cycles + 32'd1;
      if (i_timeout && !(&r_timeouts))    r_timeouts   <= r_timeouts + 16'd1;
    end
  end

  assign o_ops        = r_ops;
  assign o_sin_cycles = r_sin_cycles;
  assign o_timeouts   = r_timeouts;
endmodule

// File: rtl/fp_alu_issue.sv
// Issue/sequencing stage in front of the FP ALU: one op in flight, fsin start/done with timeout.
// Optional stats counters are enabled by defining FP_ALU_ISSUE_STATS_EN.
module fp_alu_issue
  import fp_alu_pkg::*;
#(
  parameter int TAG_W       = 4,
  parameter int SIN_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic              clk,
  input  logic              reset,
  fp_alu_issue_if.slave     bus,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [2:0]        alu_op,
  output logic              alu_fsin,
  input  logic [31:0]       alu_res,
  input  logic              alu_done,
  output logic              busy
`ifdef FP_ALU_ISSUE_STATS_EN
  ,output logic [31:0]      stat_ops
  ,output logic [31:0]      stat_sin_cycles
  ,output logic [15:0]      stat_timeouts
`endif
);
  state_t           r_state, w_next;
  logic [31:0]      r_alu_a, r_alu_b, r_res;
  logic [2:0]       r_alu_op;
  logic             r_alu_fsin, r_err;
  logic [TAG_W-1:0] r_tag;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done_ok, w_timeout;

  always_comb begin
    w_next    = r_state;
    w_done_ok = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op == OP_FSIN)     w_next = ST_SIN_START;
          else if (bus.req_op > OP_FSIN) w_next = ST_RESP;
          else                           w_next = ST_EXEC;
        end
      end
      ST_EXEC:      w_next = ST_RESP;
      ST_SIN_START: w_next = ST_SIN_WAIT;
      ST_SIN_WAIT: begin
        // Count of zero marks the first wait cycle, where Done may still be left over from the previous op.
        if ((r_cnt != '0) && alu_done) begin
          w_done_ok = 1'b1;
          w_next    = ST_RESP;
        end else if (r_cnt == CNT_W'(SIN_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = ST_RESP;
        end
      end
      ST_RESP:  if (bus.resp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_alu_fsin <= 1'b0;
      r_res      <= '0;
      r_tag      <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_next;
      r_alu_fsin <= (w_next == ST_SIN_START);
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_alu_a <= bus.req_a;
            r_alu_b <= bus.req_b;
            r_tag   <= bus.req_tag;
            if (bus.req_op <= OP_FSIN) begin
              r_alu_op <= bus.req_op;
            end else begin
              r_res <= '0;
              r_err <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          r_res <= alu_res;
          r_err <= 1'b0;
        end
        ST_SIN_START: r_cnt <= '0;
        ST_SIN_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_done_ok) begin
            r_res <= alu_res;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_res <= FP_QNAN;
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_op         = r_alu_op;
  assign alu_fsin       = r_alu_fsin;
  assign busy           = (r_state != ST_IDLE);
  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_res   = r_res;
  assign bus.resp_tag   = r_tag;
  assign bus.resp_err   = r_err;

`ifdef FP_ALU_ISSUE_STATS_EN
  fp_alu_issue_stats u_stats (
    .clk          (clk),
    .reset        (reset),
    .i_resp_hs    ((r_state == ST_RESP) && bus.resp_ready),
    .i_sin_wait   (r_state == ST_SIN_WAIT),
    .i_timeout    (w_timeout),
    .o_ops        (stat_ops),
    .o_sin_cycles (stat_sin_cycles),
    .o_timeouts   (stat_timeouts)
  );
`endif
endmodule

// File: doc/fp_alu_issue.md
Name: fp_alu_issue

Overview:
Issue/sequencing stage directly upstream of the FP ALU. Accepts one FP operation request at a time over a valid/ready handshake and holds the operands and opcode stable on the ALU inputs. For fsin, it pulses the ALU's fsin start and waits for Done, with a timeout guard. It captures the ALU result and presents it downstream over a valid/ready response handshake with the request tag.

Parameters:
TAG_W, 4, width of request/response tag.
SIN_TIMEOUT, 64, max WAIT cycles for alu_done before an fsin op is aborted (must be >=2).
CNT_W, 7, width of timeout counter; must satisfy 2^CNT_W > SIN_TIMEOUT.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept; high only in IDLE
req_op  in  3  0 fadd, 1 fsub, 2 fmult, 3 fabs, 4 fslt, 5 fsin, 6/7 illegal
req_a  in  32  operand a (IEEE-754 single)
req_b  in  32  operand b
req_tag  in  TAG_W  opaque request id
alu_a  out  32  to ALU a, registered
alu_b  out  32  to ALU b, registered
alu_op  out  3  to ALU aluop, registered
alu_fsin  out  1  to ALU fsin start, registered
alu_res  in  32  ALU res
alu_done  in  1  ALU Done; constant 1 for non-fsin ops
resp_valid  out  1  response present
resp_ready  in  1  downstream accepts
resp_res  out  32  captured result
resp_tag  out  TAG_W  tag of completed request
resp_err  out  1  1 = illegal op or fsin timeout
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous): state=IDLE. alu_a, alu_b, alu_op, alu_fsin, resp_valid, resp_res, resp_tag, resp_err, and the counter all cleared to 0. req_ready=1 and busy=0 in the cycle after reset.
- Reset mid-operation: the in-flight op is dropped, no response is produced, and alu_fsin goes low next cycle.
- States: IDLE, EXEC, SIN_START, SIN_WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid, latch a, b, op, and tag into the alu_* and tag registers.
  - op 0-4 -> EXEC.
  - op 5 -> SIN_START.
  - op 6/7 -> RESP directly with resp_res=0 and resp_err=1; alu_op is not updated.
- EXEC: the ALU is combinational for ops 0-4, so capture alu_res into resp_res at the end of EXEC, set resp_err=0, -> RESP. Latency: accept at edge N, resp_valid high from edge N+2.
- SIN_START: alu_fsin=1 for exactly this one cycle; counter cleared; -> SIN_WAIT.
- SIN_WAIT: alu_fsin=0; counter increments each cycle.
  - alu_done is ignored in the first SIN_WAIT cycle (stale Done from a previous op).
  - From the second cycle on, alu_done=1 -> capture alu_res, resp_err=0, -> RESP.
  - If counter reaches SIN_TIMEOUT without done -> resp_res=32'h7FC00000 (qNaN), resp_err=1, -> RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP: resp_valid=1. resp_res, resp_tag, and resp_err are held stable until resp_ready. On resp_valid&resp_ready -> IDLE. No new request is accepted in the same cycle; back-to-back throughput is one op per 3 cycles minimum.
- alu_a, alu_b, and alu_op hold their values after completion until the next accept.
- resp_valid never depends combinationally on resp_ready. req_ready depends only on state.

Optional Feature:
FP_ALU_ISSUE_STATS_EN
- Defined: adds outputs stat_ops[31:0] (completed responses), stat_sin_cycles[31:0] (cycles spent in SIN_WAIT), and stat_timeouts[15:0].
  - All counters clear on reset and saturate at all-ones.
  - stat_ops increments on each resp handshake, including error responses.
- Undefined: the ports and counters are absent. Core behaviour and timing are identical either way.

Decomposition:
- Shared package fp_alu_pkg holds:
  - opcode constants OP_FADD=0 … OP_FSIN=5
  - FP_QNAN=32'h7FC00000
  - the state enum.
- No sub-module is needed for the core; the timeout counter is inline.
- Under the macro, the stats counters form one natural sub-module, fp_alu_issue_stats.

Test Plan:
- After reset: req_ready=1, busy=0, resp_valid=0. Issue fadd 0x3F800000+0x40000000 at edge N -> alu_op=0 at N+1; resp_valid at N+2 with resp_res=0x40400000, resp_err=0, tag echoed.
- fsin with model asserting alu_done 10 cycles after the fsin pulse -> alu_fsin high for exactly 1 cycle; resp_valid 1 cycle after done, carrying the model result and resp_err=0.
- fsin with alu_done held high from the prior op and never re-asserted -> first-cycle done ignored; after SIN_TIMEOUT cycles, resp_res=0x7FC00000, resp_err=1.
- req_op=6 -> response in 1 cycle with resp_res=0, resp_err=1; alu_op unchanged from the previous op.
- resp_ready held low for 5 cycles -> resp_* stable, req_ready=0 throughout; a request presented meanwhile is accepted only after the handshake.
- Reset asserted during SIN_WAIT -> next cycle IDLE, alu_fsin=0, resp_valid=0; a late alu_done produces no response.
